// File: rtl/strela_run_ctrl_if.sv
// Run-command handshake between the CSR block and the run sequencer.
interface strela_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_cfg_i;
    logic             cmd_exec_i;
    logic [CNT_W-1:0] cmd_timeout_i;

    modport master (
        output cmd_valid_i, cmd_cfg_i, cmd_exec_i, cmd_timeout_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_cfg_i, cmd_exec_i, cmd_timeout_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/strela_run_ctrl.sv
// Run sequencer: optional config load then optional execution on the CGRA,
// with per-phase timeout, software abort, datapath flush and cycle counters.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready_o high
// CFG_REQ  | load_configuration_o pulse
// CFG_WAIT | waiting for done_config_i
// EXE_REQ  | start_execution_o pulse
// EXE_WAIT | waiting for done_exec_output_i
// FLUSH    | reset_state_machines_o held after timeout/abort
// DONE     | one-cycle completion, raises irq_o
module strela_run_ctrl #(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    strela_run_ctrl_if.slave  cmd,
    input  logic              abort_i,
    output logic              load_configuration_o,
    output logic              start_execution_o,
    input  logic              done_config_i,
    input  logic              done_exec_output_i,
    output logic              reset_state_machines_o,
    output logic              busy_o,
    output logic [2:0]        state_o,
    output logic [1:0]        status_o,
    output logic [CNT_W-1:0]  config_cycles_o,
    output logic [CNT_W-1:0]  exec_cycles_o,
    output logic [CNT_W-1:0]  total_cycles_o,
    output logic              irq_o,
    input  logic              irq_clear_i
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CFG_REQ  = 3'd1,
        S_CFG_WAIT = 3'd2,
        S_EXE_REQ  = 3'd3,
        S_EXE_WAIT = 3'd4,
        S_FLUSH    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic             cfg_q, cfg_d;
    logic             exec_q, exec_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] cfg_cyc_q, cfg_cyc_d;
    logic [CNT_W-1:0] exe_cyc_q, exe_cyc_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [1:0]       status_q, status_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic             irq_q, irq_d;

    logic [CNT_W-1:0] phase;
    logic             timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The phase counters double as the per-phase timeout comparand.
    assign phase       = (state_q == S_EXE_WAIT) ? exe_cyc_q : cfg_cyc_q;
    assign timeout_hit = (timeout_q != '0) && (phase == timeout_q - 1'b1);

    // Next-state, counter and status logic.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        exec_d    = exec_q;
        timeout_d = timeout_q;
        cfg_cyc_d = cfg_cyc_q;
        exe_cyc_d = exe_cyc_q;
        total_d   = (state_q != S_IDLE) ? sat_inc(total_q) : total_q;
        status_d  = status_q;
        flush_d   = '0;
        irq_d     = (state_q == S_DONE) | (irq_q & ~irq_clear_i);

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid_i) begin
                    cfg_d     = cmd.cmd_cfg_i;
                    exec_d    = cmd.cmd_exec_i;
                    timeout_d = cmd.cmd_timeout_i;
                    cfg_cyc_d = '0;
                    exe_cyc_d = '0;
                    total_d   = '0;
                    status_d  = ST_OK;
                    state_d   = cmd.cmd_cfg_i  ? S_CFG_REQ :
                                cmd.cmd_exec_i ? S_EXE_REQ : S_DONE;
                end
            end
            S_CFG_REQ, S_EXE_REQ: begin
                if (abort_i) begin
                    status_d = ST_ABORT;
                    state_d  = S_FLUSH;
                end else begin
                    state_d = (state_q == S_CFG_REQ) ? S_CFG_WAIT : S_EXE_WAIT;
                end
            end
            S_CFG_WAIT: begin
                if (abort_i) begin
                    status_d = ST_ABORT;
                    state_d  = S_FLUSH;
                end else if (done_config_i) begin
                    state_d = exec_q ? S_EXE_REQ : S_DONE;
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_FLUSH;
                end else begin
                    cfg_cyc_d = sat_inc(cfg_cyc_q);
                end
            end
            S_EXE_WAIT: begin
                if (abort_i) begin
                    status_d = ST_ABORT;
                    state_d  = S_FLUSH;
                end else if (done_exec_output_i) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_FLUSH;
                end else begin
                    exe_cyc_d = sat_inc(exe_cyc_q);
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cfg_q     <= 1'b0;
            exec_q    <= 1'b0;
            timeout_q <= '0;
            cfg_cyc_q <= '0;
            exe_cyc_q <= '0;
            total_q   <= '0;
            status_q  <= ST_OK;
            flush_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            exec_q    <= exec_d;
            timeout_q <= timeout_d;
            cfg_cyc_q <= cfg_cyc_d;
            exe_cyc_q <= exe_cyc_d;
            total_q   <= total_d;
            status_q  <= status_d;
            flush_q   <= flush_d;
            irq_q     <= irq_d;
        end
    end

    assign cmd.cmd_ready_o            = (state_q == S_IDLE);
    assign load_configuration_o       = (state_q == S_CFG_REQ);
    assign start_execution_o          = (state_q == S_EXE_REQ);
    assign reset_state_machines_o     = (state_q == S_FLUSH);
    assign busy_o                     = (state_q != S_IDLE);
    assign state_o                    = state_q;
    assign status_o                   = status_q;
    assign config_cycles_o            = cfg_cyc_q;
    assign exec_cycles_o              = exe_cyc_q;
    assign total_cycles_o             = total_q;
    assign irq_o                      = irq_q;

endmodule

// File: tb/tb_strela_run_ctrl.sv
// Scoreboard bench for strela_run_ctrl: each run pushes its expected outcome,
// which is popped and compared once the sequencer returns to IDLE.
module tb_strela_run_ctrl;

    localparam int CNT_W = 32;

    typedef struct {
        int status;
        int cfg_cyc;   // -1: not compared
        int exe_cyc;
        int total;
        int loads;
        int starts;
        int flushes;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             abort_i;
    logic             load_configuration_o;
    logic             start_execution_o;
    logic             done_config_i;
    logic             done_exec_output_i;
    logic             reset_state_machines_o;
    logic             busy_o;
    logic [2:0]       state_o;
    logic [1:0]       status_o;
    logic [CNT_W-1:0] config_cycles_o;
    logic [CNT_W-1:0] exec_cycles_o;
    logic [CNT_W-1:0] total_cycles_o;
    logic             irq_o;
    logic             irq_clear_i;

    strela_run_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

    strela_run_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .cmd                    (cmd_if.slave),
        .abort_i                (abort_i),
        .load_configuration_o   (load_configuration_o),
        .start_execution_o      (start_execution_o),
        .done_config_i          (done_config_i),
        .done_exec_output_i     (done_exec_output_i),
        .reset_state_machines_o (reset_state_machines_o),
        .busy_o                 (busy_o),
        .state_o                (state_o),
        .status_o               (status_o),
        .config_cycles_o        (config_cycles_o),
        .exec_cycles_o          (exec_cycles_o),
        .total_cycles_o         (total_cycles_o),
        .irq_o                  (irq_o),
        .irq_clear_i            (irq_clear_i)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        cmd_if.cmd_valid_i   = 1'b0;
        cmd_if.cmd_cfg_i     = 1'b0;
        cmd_if.cmd_exec_i    = 1'b0;
        cmd_if.cmd_timeout_i = '0;
        abort_i              = 1'b0;
        done_config_i        = 1'b0;
        done_exec_output_i   = 1'b0;
        irq_clear_i          = 1'b0;
    endtask

    // Issue one command and play the datapath: done/abort raised in the k-th
    // cycle of the relevant WAIT state (0 = never). Called at a negedge.
    task automatic run(input string name, input bit cfg, input bit exe,
                       input int tmo, input int cdone_k, input int edone_k,
                       input int abort_k, input bit clr_in_done,
                       input bit poke_busy, input exp_t e);
        int   k_cw = 0, k_ew = 0, loads = 0, starts = 0, flushes = 0;
        int   bad_ready = 0;
        bit   fin = 0;
        exp_t got_e;
        sb_q.push_back(e);
        cmd_if.cmd_valid_i   = 1'b1;
        cmd_if.cmd_cfg_i     = cfg;
        cmd_if.cmd_exec_i    = exe;
        cmd_if.cmd_timeout_i = CNT_W'(tmo);
        @(negedge clk_i);
        clear_inputs();
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            loads   += int'(load_configuration_o);
            starts  += int'(start_execution_o);
            flushes += int'(reset_state_machines_o);
            if (cmd_if.cmd_ready_o || !busy_o) bad_ready++;
            clear_inputs();
            case (state_o)
                3'd2: begin
                    k_cw++;
                    if (k_cw == cdone_k) done_config_i = 1'b1;
                    if (k_cw == abort_k) abort_i = 1'b1;
                end
                3'd4: begin
                    k_ew++;
                    if (k_ew == edone_k) done_exec_output_i = 1'b1;
                    if (poke_busy && k_ew == 3) begin
                        cmd_if.cmd_valid_i = 1'b1;
                        cmd_if.cmd_cfg_i   = 1'b1;
                    end
                end
                3'd6: begin
                    if (clr_in_done) irq_clear_i = 1'b1;
                    fin = 1;
                end
                default: ;
            endcase
            @(negedge clk_i);
        end
        clear_inputs();
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: DONE never reached, state %0d", name, state_o);
        end
        got_e = sb_q.pop_front();
        check_eq({name, "_state"},   state_o, 0);
        check_eq({name, "_ready"},   cmd_if.cmd_ready_o, 1);
        check_eq({name, "_status"},  status_o, got_e.status);
        if (got_e.cfg_cyc >= 0) check_eq({name, "_cfgcyc"}, config_cycles_o, got_e.cfg_cyc);
        check_eq({name, "_execyc"},  exec_cycles_o, got_e.exe_cyc);
        check_eq({name, "_total"},   total_cycles_o, got_e.total);
        check_eq({name, "_loads"},   loads, got_e.loads);
        check_eq({name, "_starts"},  starts, got_e.starts);
        check_eq({name, "_flush"},   flushes, got_e.flushes);
        check_eq({name, "_irq"},     irq_o, 1);
        check_eq({name, "_rdybusy"}, bad_ready, 0);
    endtask

    initial begin
        int n;
        clear_inputs();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_ready", cmd_if.cmd_ready_o, 1);
        check_eq("rst_busy",  busy_o, 0);
        check_eq("rst_irq",   irq_o, 0);
        check_eq("rst_total", total_cycles_o, 0);
        check_eq("rst_load",  load_configuration_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        //   name   cfg exe tmo cd ed ab clr poke  status cfg exe total ld st fl
        run("t1", 1, 1, 0, 5, 11, 0, 0, 1, '{0,  4, 10, 19, 1, 1, 0});
        run("t2", 0, 1, 8, 0,  0, 0, 0, 0, '{1,  0,  7, 12, 0, 1, 2});
        run("t3", 1, 1, 0, 3,  0, 3, 0, 0, '{2, -1,  0,  7, 1, 0, 2});
        run("t4", 0, 0, 0, 0,  0, 0, 1, 0, '{0,  0,  0,  1, 0, 0, 0});

        // Asynchronous reset while waiting on execution.
        cmd_if.cmd_valid_i = 1'b1;
        cmd_if.cmd_exec_i  = 1'b1;
        @(negedge clk_i);
        clear_inputs();
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            if (state_o == 3'd4) n++;
            @(negedge clk_i);
        end
        check_eq("r_pre_state", state_o, 4);
        #2 rst_i = 1'b1;
        #1;
        check_eq("r_state", state_o, 0);
        check_eq("r_ready", cmd_if.cmd_ready_o, 1);
        check_eq("r_busy",  busy_o, 0);
        check_eq("r_irq",   irq_o, 0);
        check_eq("r_exec",  exec_cycles_o, 0);
        check_eq("r_total", total_cycles_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        run("t6a", 1, 1, 1, 1, 1, 0, 0, 0, '{0, 0, 0, 5, 1, 1, 0});
        run("t6b", 0, 1, 1, 0, 0, 0, 0, 0, '{1, 0, 0, 5, 0, 1, 2});
        run("t7",  1, 0, 3, 0, 0, 0, 0, 0, '{1, 2, 0, 7, 1, 0, 2});

        irq_clear_i = 1'b1;
        @(negedge clk_i);
        irq_clear_i = 1'b0;
        check_eq("irq_clr", irq_o, 0);
        check_eq("hold_status", status_o, 1);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strela_run_ctrl.md
Name: strela_run_ctrl

Overview:
Sequencer between the CSR block and the CGRA datapath. Accepts one run command (optional configuration load, optional execution), issues single-cycle load_configuration/start_execution pulses, waits on the datapath done flags and measures per-phase and total cycle counts. Enforces a programmable timeout and a software abort, both of which flush the datapath state machines. Completion is reported with a sticky status and a level interrupt.

Parameters:
CNT_W, 32, width of the timeout value and all cycle counters
FLUSH_CYCLES, 2, number of cycles reset_state_machines_o is held on timeout/abort (≥1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  run request
cmd_ready_o  out  1  high only in IDLE
cmd_cfg_i  in  1  run configuration phase
cmd_exec_i  in  1  run execution phase
cmd_timeout_i  in  CNT_W  per-phase timeout in cycles; 0 = disabled
abort_i  in  1  software abort (level, sampled each cycle)
load_configuration_o  out  1  1-cycle pulse to config loader
start_execution_o  out  1  1-cycle pulse to datapath
done_config_i  in  1  config load done (level)
done_exec_output_i  in  1  execution/output done (level)
reset_state_machines_o  out  1  datapath flush
busy_o  out  1  state != IDLE
state_o  out  3  encoded state for CSR readback
status_o  out  2  00 ok, 01 timeout, 10 abort
config_cycles_o  out  CNT_W  CFG_WAIT cycles of last run
exec_cycles_o  out  CNT_W  EXE_WAIT cycles of last run
total_cycles_o  out  CNT_W  cycles from accept to DONE of last run
irq_o  out  1  completion interrupt (level)
irq_clear_i  in  1  clears irq_o

Behaviour:
- Reset (async, rst_i=1): state IDLE (0); all outputs 0 except cmd_ready_o=1; counters and status 0.
- States / encodings: IDLE 0, CFG_REQ 1, CFG_WAIT 2, EXE_REQ 3, EXE_WAIT 4, FLUSH 5, DONE 6.
- Accept: cmd_valid_i & cmd_ready_o at an edge → latch cfg/exec/timeout; clear status, all counters. Next state: CFG_REQ if cfg, else EXE_REQ if exec, else DONE.
- CFG_REQ: load_configuration_o=1 for exactly this cycle (registered Moore output); → CFG_WAIT. done_config_i ignored here.
- CFG_WAIT: phase counter cleared on entry. done_config_i=1 → config_cycles_o = phase count (WAIT cycles before done); → EXE_REQ if exec else DONE. Otherwise increment.
- EXE_REQ / EXE_WAIT: same as above with start_execution_o, done_exec_output_i, exec_cycles_o; done → DONE.
- Timeout: in a WAIT state, timeout≠0, no done, and phase count == timeout−1 → status 01, → FLUSH. Done wins over timeout in the same cycle.
- Abort: abort_i=1 in CFG_REQ/CFG_WAIT/EXE_REQ/EXE_WAIT → status 10, → FLUSH. Abort wins over done and timeout. Ignored in IDLE, FLUSH, DONE. A REQ pulse already emitted is not retracted.
- FLUSH: reset_state_machines_o=1 for FLUSH_CYCLES consecutive cycles; → DONE.
- DONE: one cycle; irq_o set; → IDLE (cmd_ready_o=1 next cycle).
- irq_o: set on DONE, cleared by irq_clear_i. Set wins if both occur in the same cycle.
- total_cycles_o: cleared on accept, increments every non-IDLE cycle up to and including DONE.
- All counters saturate at all-ones; no wrap.
- Counter/status values hold until the next accept.
- cmd_valid_i while busy is ignored (no queueing).

Test Plan:
- cfg+exec, timeout=0; done_config_i at 5th CFG_WAIT cycle, done_exec_output_i at 11th EXE_WAIT cycle → one load pulse, one start pulse; config_cycles=4, exec_cycles=10, total=1+5+1+11+1=19, status 00, irq_o=1.
- exec only, timeout=8, done never → start pulse, FLUSH after 8 EXE_WAIT cycles, reset_state_machines_o high 2 cycles, status 01, exec_cycles=7, irq_o=1.
- cfg+exec, abort_i in 3rd CFG_WAIT cycle with done_config_i also high → no start pulse, status 10, FLUSH then DONE.
- cfg=0, exec=0 → DONE next cycle; total=1, status 00, irq set. Asserting irq_clear_i in the same cycle as the DONE set → irq_o stays 1.
- rst_i asserted mid-EXE_WAIT → all outputs zero asynchronously, cmd_ready_o=1. A new command after release runs normally.
- timeout=1 with done arriving in the 1st WAIT cycle → done wins, status 00, phase count 0.
